// File: rtl/pwm_update_sched.sv
// pwm_update_sched: start/drain sequencer for the PWM counter
// and period-boundary scheduler for the per-channel compare pairs.
module pwm_update_sched #(
  parameter int CH_NUM = 16,
  parameter int WIDTH  = 16,
  parameter int RCR_W  = 8
) (
  input  logic                      clk_psc_i,
  input  logic                      rst_n_i,
  input  logic                      run_req_i,
  input  logic [RCR_W-1:0]          rcr_i,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  input  logic [$clog2(CH_NUM)-1:0] wr_ch_i,
  input  logic [WIDTH-1:0]          wr_on_i,
  input  logic [WIDTH-1:0]          wr_off_i,
  input  logic                      ck_cnt_i,
  input  logic                      overflow_i,
  output logic                      cnt_en_o,
  output logic [CH_NUM*WIDTH-1:0]   ch_on_o,
  output logic [CH_NUM*WIDTH-1:0]   ch_off_o,
  output logic [CH_NUM-1:0]         pend_o,
  output logic                      upd_evt_o,
  output logic [1:0]                state_o
);

  localparam int CH_W = $clog2(CH_NUM);
  localparam logic [CH_W:0] CH_LIM = CH_NUM[CH_W:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [RCR_W-1:0]          rep_cnt_q, rep_cnt_d;
  logic                      ck_d1_q, ck_d1_d;
  logic                      upd_evt_q, upd_evt_d;
  logic [CH_NUM-1:0]         pend_q, pend_d;
  logic [WIDTH-1:0]          stg_on_q [CH_NUM];
  logic [WIDTH-1:0]          stg_on_d [CH_NUM];
  logic [WIDTH-1:0]          stg_off_q [CH_NUM];
  logic [WIDTH-1:0]          stg_off_d [CH_NUM];
  logic [CH_NUM*WIDTH-1:0]   ch_on_q, ch_on_d;
  logic [CH_NUM*WIDTH-1:0]   ch_off_q, ch_off_d;

  logic                      pe;
  logic                      commit;
  logic                      wr_fire;
  logic                      ch_ok;
  logic [CH_NUM-1:0]         wr_hit;

  assign wr_ready_o = (state_q == IDLE) || (state_q == RUN);
  assign cnt_en_o   = (state_q != IDLE);
  assign state_o    = state_q;
  assign ch_on_o    = ch_on_q;
  assign ch_off_o   = ch_off_q;
  assign pend_o     = pend_q;
  assign upd_evt_o  = upd_evt_q;

  // One boundary per wrap: overflow qualified by last cycle's tick.
  assign pe      = overflow_i & ck_d1_q;
  assign wr_fire = wr_valid_i & wr_ready_o;
  assign ch_ok   = ({1'b0, wr_ch_i} < CH_LIM);

  // One-hot target channel; out-of-range writes are swallowed.
  always_comb begin
    wr_hit = '0;
    if (wr_fire && ch_ok) begin
      wr_hit = CH_NUM'(1) << wr_ch_i;
    end
  end

  // Sequencer next state, repetition countdown and commit decision.
  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    commit    = 1'b0;
    upd_evt_d = 1'b0;
    ck_d1_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run_req_i) begin
          state_d = START;
        end
      end
      START: begin
        rep_cnt_d = rcr_i;
        state_d   = RUN;
      end
      RUN: begin
        ck_d1_d = ck_cnt_i;
        if (pe) begin
          if (rep_cnt_q == '0) begin
            commit    = 1'b1;
            upd_evt_d = 1'b1;
            rep_cnt_d = rcr_i;
          end else begin
            rep_cnt_d = rep_cnt_q - RCR_W'(1);
          end
        end
        if (!run_req_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        ck_d1_d = ck_cnt_i;
        if (pe) begin
          commit    = 1'b1;
          upd_evt_d = |pend_q;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Staging, pending mask and active compare next values.
  always_comb begin
    ch_on_d   = ch_on_q;
    ch_off_d  = ch_off_q;
    pend_d    = pend_q;
    stg_on_d  = stg_on_q;
    stg_off_d = stg_off_q;
    if (commit) begin
      for (int n = 0; n < CH_NUM; n++) begin
        if (pend_q[n]) begin
          ch_on_d[n*WIDTH +: WIDTH]  = stg_on_q[n];
          ch_off_d[n*WIDTH +: WIDTH] = stg_off_q[n];
        end
      end
      pend_d = '0;
    end
    for (int n = 0; n < CH_NUM; n++) begin
      if (wr_hit[n]) begin
        stg_on_d[n]  = wr_on_i;
        stg_off_d[n] = wr_off_i;
        if (state_q == IDLE) begin
          ch_on_d[n*WIDTH +: WIDTH]  = wr_on_i;
          ch_off_d[n*WIDTH +: WIDTH] = wr_off_i;
          pend_d[n] = 1'b0;
        end else begin
          pend_d[n] = 1'b1;
        end
      end
    end
  end

  // Sequencer and repetition registers.
  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      rep_cnt_q <= '0;
      ck_d1_q   <= 1'b0;
      upd_evt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rep_cnt_q <= rep_cnt_d;
      ck_d1_q   <= ck_d1_d;
      upd_evt_q <= upd_evt_d;
    end
  end

  // Staging and active compare registers.
  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int n = 0; n < CH_NUM; n++) begin
        stg_on_q[n]  <= '0;
        stg_off_q[n] <= '0;
      end
      ch_on_q  <= '0;
      ch_off_q <= '0;
      pend_q   <= '0;
    end else begin
      for (int n = 0; n < CH_NUM; n++) begin
        stg_on_q[n]  <= stg_on_d[n];
        stg_off_q[n] <= stg_off_d[n];
      end
      ch_on_q  <= ch_on_d;
      ch_off_q <= ch_off_d;
      pend_q   <= pend_d;
    end
  end

endmodule

// File: tb/tb_pwm_update_sched.sv
// tb_pwm_update_sched: random run/stop/write traffic against a
// period-count reference model, checked through a scoreboard queue.
module tb_pwm_update_sched;

  localparam int CH = 16;
  localparam int W  = 16;
  localparam int R  = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            run_req_i;
  logic [R-1:0]    rcr_i;
  logic            wr_valid_i;
  logic            wr_ready_o;
  logic [3:0]      wr_ch_i;
  logic [W-1:0]    wr_on_i;
  logic [W-1:0]    wr_off_i;
  logic            ck_cnt_i;
  logic            overflow_i;
  logic            cnt_en_o;
  logic [CH*W-1:0] ch_on_o;
  logic [CH*W-1:0] ch_off_o;
  logic [CH-1:0]   pend_o;
  logic            upd_evt_o;
  logic [1:0]      state_o;

  pwm_update_sched #(
    .CH_NUM(CH), .WIDTH(W), .RCR_W(R)
  ) dut (
    .clk_psc_i (clk),
    .rst_n_i   (rst_n),
    .run_req_i (run_req_i),
    .rcr_i     (rcr_i),
    .wr_valid_i(wr_valid_i),
    .wr_ready_o(wr_ready_o),
    .wr_ch_i   (wr_ch_i),
    .wr_on_i   (wr_on_i),
    .wr_off_i  (wr_off_i),
    .ck_cnt_i  (ck_cnt_i),
    .overflow_i(overflow_i),
    .cnt_en_o  (cnt_en_o),
    .ch_on_o   (ch_on_o),
    .ch_off_o  (ch_off_o),
    .pend_o    (pend_o),
    .upd_evt_o (upd_evt_o),
    .state_o   (state_o)
  );

  // Environment: the shared period counter with auto-reload arr.
  int         arr;
  logic [W-1:0] cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      overflow_i <= 1'b0;
    end else if (!cnt_en_o) begin
      cnt <= '0;
      overflow_i <= 1'b0;
    end else if (ck_cnt_i) begin
      if (cnt == W'(arr)) begin
        cnt <= '0;
        overflow_i <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
        overflow_i <= 1'b0;
      end
    end
  end

  typedef struct packed {
    logic [1:0]      st;
    logic            en;
    logic            rdy;
    logic            evt;
    logic [CH-1:0]   pend;
    logic [CH*W-1:0] on;
    logic [CH*W-1:0] off;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_evt  = 0;

  task automatic chk(input string nm,
                     input logic [CH*W-1:0] act,
                     input logic [CH*W-1:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h @%0t",
               nm, act, want, $time);
    end
  endtask

  // Monitor: one expected record per clock edge.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("state_o", state_o, e.st);
      chk("cnt_en_o", cnt_en_o, e.en);
      chk("wr_ready_o", wr_ready_o, e.rdy);
      chk("upd_evt_o", upd_evt_o, e.evt);
      chk("pend_o", pend_o, e.pend);
      chk("ch_on_o", ch_on_o, e.on);
      chk("ch_off_o", ch_off_o, e.off);
    end
  end

  // Reference model. Phases: 0 stopped, 1 starting,
  // 2 running, 3 draining. A commit happens on every
  // (rcr+1)-th boundary counted from the start of a run.
  int           m_ph;
  int           m_pecnt;
  int           m_rcr;
  logic         m_ckd1;
  logic [W-1:0] m_on [CH];
  logic [W-1:0] m_off [CH];
  logic [W-1:0] m_son [CH];
  logic [W-1:0] m_soff [CH];
  logic [CH-1:0] m_pend;

  task automatic model_reset();
    m_ph = 0;
    m_pecnt = 0;
    m_rcr = 0;
    m_ckd1 = 1'b0;
    m_pend = '0;
    for (int n = 0; n < CH; n++) begin
      m_on[n] = '0;
      m_off[n] = '0;
      m_son[n] = '0;
      m_soff[n] = '0;
    end
  endtask

  task automatic model_apply();
    for (int n = 0; n < CH; n++) begin
      if (m_pend[n]) begin
        m_on[n] = m_son[n];
        m_off[n] = m_soff[n];
      end
    end
    m_pend = '0;
  endtask

  task automatic model_step(output exp_t e);
    logic pe;
    logic fire;
    int   nph;
    pe   = overflow_i & m_ckd1;
    fire = wr_valid_i & (m_ph == 0 || m_ph == 2);
    nph  = m_ph;
    e    = '0;
    case (m_ph)
      0: begin
        if (fire) begin
          m_on[wr_ch_i] = wr_on_i;
          m_off[wr_ch_i] = wr_off_i;
          m_son[wr_ch_i] = wr_on_i;
          m_soff[wr_ch_i] = wr_off_i;
          m_pend[wr_ch_i] = 1'b0;
        end
        if (run_req_i) nph = 1;
      end
      1: begin
        m_pecnt = 0;
        m_rcr = int'(rcr_i);
        nph = 2;
      end
      2: begin
        if (pe) begin
          m_pecnt++;
          if (m_pecnt % (m_rcr + 1) == 0) begin
            model_apply();
            e.evt = 1'b1;
          end
        end
        if (fire) begin
          m_son[wr_ch_i] = wr_on_i;
          m_soff[wr_ch_i] = wr_off_i;
          m_pend[wr_ch_i] = 1'b1;
        end
        if (!run_req_i) nph = 3;
      end
      default: begin
        if (pe) begin
          e.evt = (m_pend != '0);
          model_apply();
          nph = 0;
        end
      end
    endcase
    m_ckd1 = (m_ph == 2 || m_ph == 3) ? ck_cnt_i : 1'b0;
    m_ph = nph;
    if (e.evt) n_evt++;
    e.st = 2'(m_ph);
    e.en = (m_ph != 0);
    e.rdy = (m_ph == 0 || m_ph == 2);
    e.pend = m_pend;
    for (int n = 0; n < CH; n++) begin
      e.on[n*W +: W] = m_on[n];
      e.off[n*W +: W] = m_off[n];
    end
  endtask

  // Drive one cycle of inputs, predict, record after the edge.
  task automatic cyc(input logic run, input logic v,
                     input logic [3:0] ch,
                     input logic [W-1:0] on,
                     input logic [W-1:0] off,
                     input logic ck);
    exp_t e;
    run_req_i = run;
    wr_valid_i = v;
    wr_ch_i = ch;
    wr_on_i = on;
    wr_off_i = off;
    ck_cnt_i = ck;
    model_step(e);
    @(posedge clk);
    q.push_back(e);
    #2;
  endtask

  task automatic rcyc(input logic run, input int wp,
                      input int ckp);
    logic v;
    logic ck;
    v  = ($urandom_range(0, 99) < wp);
    ck = ($urandom_range(1, 4) <= ckp);
    cyc(run, v, 4'($urandom_range(0, 15)),
        W'($urandom), W'($urandom), ck);
  endtask

  task automatic to_idle(input int ckp);
    int n;
    n = 0;
    while (m_ph != 0 && n < 1000) begin
      rcyc(1'b0, 30, ckp);
      n++;
    end
    n_chk++;
    if (m_ph != 0) begin
      n_fail++;
      $display("FAIL drain_bound: phase %0d, required 0", m_ph);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, state_o, 0);
    chk({tag, "_cnt_en"}, cnt_en_o, 0);
    chk({tag, "_pend"}, pend_o, 0);
    chk({tag, "_evt"}, upd_evt_o, 0);
    chk({tag, "_on"}, ch_on_o, 0);
    chk({tag, "_off"}, ch_off_o, 0);
  endtask

  task automatic idle_inputs();
    run_req_i = 1'b0;
    wr_valid_i = 1'b0;
    wr_ch_i = '0;
    wr_on_i = '0;
    wr_off_i = '0;
    ck_cnt_i = 1'b0;
  endtask

  initial begin
    logic run;
    rst_n = 1'b0;
    arr = 3;
    rcr_i = '0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Direct write while stopped.
    cyc(0, 1, 4'd3, 16'h0010, 16'h0800, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);

    // Commit on every boundary.
    arr = 3;
    rcr_i = 8'd0;
    repeat (4) cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 1, 4'd0, 16'h0000, 16'h0100, 1);
    repeat (20) cyc(1, 0, 0, 0, 0, 1);
    to_idle(4);

    // Commit every third boundary.
    arr = 2;
    rcr_i = 8'd2;
    repeat (2) cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 1, 4'd5, 16'h1234, 16'h5678, 1);
    repeat (40) cyc(1, 0, 0, 0, 0, 1);
    to_idle(4);

    // Single-cycle periods: writes collide with commits.
    arr = 0;
    rcr_i = 8'd0;
    repeat (3) cyc(1, 0, 0, 0, 0, 1);
    repeat (20) cyc(1, 1, 4'd7, W'($urandom), W'($urandom), 1);
    to_idle(4);

    // Stop mid-period with a pending channel, re-request in drain.
    arr = 4;
    rcr_i = 8'd0;
    repeat (4) cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 1, 4'd1, 16'h00aa, 16'h0bbb, 1);
    cyc(0, 1, 4'd2, 16'h0111, 16'h0222, 1);
    for (int i = 0; i < 200 && m_ph == 3; i++) begin
      cyc(1, 0, 0, 0, 0, 1);
    end
    repeat (6) cyc(1, 0, 0, 0, 0, 1);
    to_idle(4);

    // Stuck overflow, commit every second cycle.
    arr = 0;
    rcr_i = 8'd1;
    repeat (3) cyc(1, 0, 0, 0, 0, 1);
    repeat (20) rcyc(1, 40, 4);
    to_idle(4);

    // Random segments.
    for (int s = 0; s < 14; s++) begin
      int ckp;
      int wp;
      arr = $urandom_range(0, 4);
      rcr_i = R'($urandom_range(0, 3));
      ckp = $urandom_range(1, 4);
      wp = $urandom_range(10, 60);
      run = 1'b1;
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 99) < 4) run = ~run;
        rcyc(run, wp, ckp);
      end
      to_idle(ckp);
    end

    // Asynchronous reset in the middle of a run.
    arr = 5;
    rcr_i = 8'd1;
    repeat (30) rcyc(1, 50, 3);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk_reset("arst");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    cyc(0, 1, 4'd9, 16'h0042, 16'h0099, 0);
    arr = 1;
    rcr_i = 8'd0;
    repeat (30) rcyc(1, 40, 4);
    to_idle(4);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_update_sched.md
# pwm_update_sched

Sequencer and update scheduler for the shared PWM period counter and the 16 per-channel compare pairs. It takes duty writes from the I2C register file over a valid/ready handshake and stages them. It commits staged values to the active compare outputs only at period boundaries, after a programmable repetition count. It also drives the counter enable through a start/drain state machine, so a period is never truncated on stop.

## Interface
- CH_NUM, 16, number of PWM channels
- WIDTH, 16, compare/counter width
- RCR_W, 8, repetition counter width
- clk_psc_i  in  1  prescaler clock
- rst_n_i  in  1  reset, asynchronous, active-low
- run_req_i  in  1  level; 1 = run PWM, 0 = stop at end of current period
- rcr_i  in  RCR_W  repetition count; commit every rcr_i+1 periods; sampled at reload points
- wr_valid_i  in  1  write request
- wr_ready_o  out  1  write accept
- wr_ch_i  in  $clog2(CH_NUM)  target channel
- wr_on_i  in  WIDTH  ON compare value
- wr_off_i  in  WIDTH  OFF compare value
- ck_cnt_i  in  1  counter tick enable (same signal fed to counter)
- overflow_i  in  1  counter overflow flag (registered; updates the cycle after a tick)
- cnt_en_o  out  1  counter enable
- ch_on_o  out  CH_NUM*WIDTH  active ON values, channel n at [n*WIDTH +: WIDTH]
- ch_off_o  out  CH_NUM*WIDTH  active OFF values, same packing
- pend_o  out  CH_NUM  staged-but-uncommitted mask
- upd_evt_o  out  1  one-cycle pulse on every commit
- state_o  out  2  FSM state: 0 IDLE, 1 START, 2 RUN, 3 DRAIN

## Operation
- Reset values are all 0: every output, staging regs, rep_cnt, ck_d1. state_o = IDLE.
- Write accept: wr_fire = wr_valid_i & wr_ready_o.
  - wr_ready_o = 1 in IDLE and RUN, 0 in START and DRAIN.
- On wr_fire in RUN:
  - stg_on/stg_off[wr_ch_i] take the write data.
  - pend[wr_ch_i] is set.
- On wr_fire in IDLE:
  - The write goes straight to ch_on_o/ch_off_o[wr_ch_i] and to staging.
  - pend is cleared for that channel.
  - upd_evt_o is not pulsed.
- wr_ch_i >= CH_NUM: the write is accepted and discarded.
- Period-boundary event: pe = overflow_i & ck_d1, where ck_d1 is ck_cnt_i registered and forced to 0 outside RUN/DRAIN.
  - This gives one pe per wrap, including ARR = 0, where overflow_i stays high.
- Repetition, on each pe in RUN:
  - If rep_cnt == 0: commit, then rep_cnt <= rcr_i.
  - Otherwise rep_cnt <= rep_cnt - 1.
- Commit:
  - For every n with pend[n]=1, ch_on_o/ch_off_o[n] <= stg_on/stg_off[n].
  - pend <= 0, except channels written in the same cycle, which stay set with the new data staged.
  - upd_evt_o = 1 for that cycle.
- FSM:
  - IDLE: cnt_en_o=0. run_req_i=1 -> START.
  - START (1 cycle): cnt_en_o=1, rep_cnt <= rcr_i, ck_d1 cleared. -> RUN.
  - RUN: cnt_en_o=1. run_req_i=0 -> DRAIN.
  - DRAIN: cnt_en_o=1, no repetition countdown. On pe: force commit (if pend != 0, pulse upd_evt_o), then -> IDLE with cnt_en_o=0 the same edge. run_req_i returning to 1 during DRAIN: stay in DRAIN until pe, then go to IDLE. A new START follows from IDLE on the next cycle.
- A pe coinciding with run_req_i falling in RUN is handled as RUN: repetition/commit applies, then go to DRAIN.

## Timing
- IDLE write: active output updates on the edge that accepts it (1-cycle latency).
- RUN commit: ch_*_o and upd_evt_o change on the clk_psc_i edge where pe=1. pe is 1 cycle after the tick that wrapped the counter.
- cnt_en_o rises on the edge entering START (1 cycle after run_req_i is sampled high).
- cnt_en_o falls on the edge where pe is seen in DRAIN. The counter therefore completes the full period and restarts from 0.
- Asynchronous reset mid-operation: all staging is lost, cnt_en_o=0 immediately, and the FSM is in IDLE.

## Test plan
- Reset then IDLE write ch3 on=0x0010 off=0x0800 -> ch3 active = values next edge, pend_o=0, upd_evt_o stays 0.
- Run with rcr_i=0, write ch0 off=0x0100 mid-period -> pend_o[0]=1 until next pe; on pe ch0 updates, upd_evt_o pulses once, pend_o=0.
- rcr_i=2, write ch5 after START -> commit only on 3rd pe; upd_evt_o pulses on pe 3, 6, 9.
- Write ch7 in the exact commit cycle -> active ch7 = old staged value, new value staged, pend_o[7]=1, committed at the next commit point.
- run_req_i drop mid-period with ch1 pending -> wr_ready_o=0; cnt_en_o stays 1 until pe; ch1 committed and cnt_en_o=0 on the same edge; state_o=IDLE.
- ARR=0 with ck_cnt_i every cycle (overflow_i stuck high) -> one pe per cycle; with rcr_i=1, upd_evt_o pulses every 2 cycles.
